// File: rtl/vga_mem_arbiter.sv
// Arbitrates one single-port video RAM between VGA scan-out and a queued CPU port.
// The display owns every visible cycle; CPU requests drain only during blanking.
module vga_mem_arbiter #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 12,
    parameter int X_BITS = 10,
    parameter int QDEPTH = 4
) (
    input  logic              char_clock,
    input  logic              reset,
    input  logic              disp_active,
    input  logic [11:0]       disp_x,
    input  logic [11:0]       disp_y,
    output logic [DATA_W-1:0] pix_rgb,
    output logic              pix_valid,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        q_level
);

    // tag        | meaning
    // TAG_NONE   | last cycle issued nothing to return (idle or CPU write)
    // TAG_DISP   | last cycle issued a display read
    // TAG_CPU_RD | last cycle issued a CPU read
    localparam int PW     = $clog2(QDEPTH);
    localparam int CW     = PW + 1;
    localparam int Y_BITS = ADDR_W - X_BITS;

    typedef enum logic [1:0] {SLOT_IDLE, SLOT_DISP, SLOT_CPU} slot_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_CPU_RD} tag_t;

    logic              q_we    [QDEPTH];
    logic [ADDR_W-1:0] q_addr  [QDEPTH];
    logic [DATA_W-1:0] q_wdata [QDEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;

    slot_t             slot;
    tag_t              tag, tag_next;
    logic              push, pop;
    logic [ADDR_W-1:0] disp_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_wdata;
    logic              unused_disp_bits;

    assign unused_disp_bits = ^{disp_x, disp_y};
    assign disp_addr = {disp_y[Y_BITS-1:0], disp_x[X_BITS-1:0]};
    assign cpu_ready = (count != CW'(QDEPTH));
    assign q_level   = 3'(count);
    assign push      = cpu_valid && cpu_ready;
    assign pop       = (slot == SLOT_CPU);

    // Slot decision; held idle during reset so the RAM bus shows its reset values.
    always_comb begin
        slot = SLOT_IDLE;
        if (!reset) begin
            if (disp_active)
                slot = SLOT_DISP;
            else if (count != '0)
                slot = SLOT_CPU;
        end
    end

    always_comb begin
        mem_addr  = last_addr;
        mem_we    = 1'b0;
        mem_wdata = last_wdata;
        tag_next  = TAG_NONE;
        case (slot)
            SLOT_DISP: begin
                mem_addr = disp_addr;
                tag_next = TAG_DISP;
            end
            SLOT_CPU: begin
                mem_addr  = q_addr[rd_ptr];
                mem_we    = q_we[rd_ptr];
                mem_wdata = q_wdata[rd_ptr];
                tag_next  = q_we[rd_ptr] ? TAG_NONE : TAG_CPU_RD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge char_clock) begin
        if (push) begin
            q_we[wr_ptr]    <= cpu_we;
            q_addr[wr_ptr]  <= cpu_addr;
            q_wdata[wr_ptr] <= cpu_wdata;
        end
    end

    always_ff @(posedge char_clock or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            last_addr  <= '0;
            last_wdata <= '0;
            tag        <= TAG_NONE;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (slot != SLOT_IDLE)
                last_addr <= mem_addr;
            if (slot == SLOT_CPU)
                last_wdata <= mem_wdata;
            tag <= tag_next;
        end
    end

    // RAM data arrives one cycle after issue; route it by the tag of that issue.
    always_ff @(posedge char_clock or posedge reset) begin
        if (reset) begin
            pix_rgb    <= '0;
            pix_valid  <= 1'b0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            case (tag)
                TAG_DISP: begin
                    pix_rgb    <= mem_rdata;
                    pix_valid  <= 1'b1;
                    cpu_rvalid <= 1'b0;
                end
                TAG_CPU_RD: begin
                    cpu_rdata  <= mem_rdata;
                    cpu_rvalid <= 1'b1;
                    pix_rgb    <= '0;
                    pix_valid  <= 1'b0;
                end
                default: begin
                    pix_rgb    <= '0;
                    pix_valid  <= 1'b0;
                    cpu_rvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: RAM model, transaction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_vga_mem_arbiter;

    logic        char_clock;
    logic        reset;
    logic        disp_active;
    logic [11:0] disp_x, disp_y;
    logic [11:0] pix_rgb;
    logic        pix_valid;
    logic        cpu_valid, cpu_ready, cpu_we;
    logic [19:0] cpu_addr;
    logic [11:0] cpu_wdata;
    logic        cpu_rvalid;
    logic [11:0] cpu_rdata;
    logic [19:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic [2:0]  q_level;

    vga_mem_arbiter dut (
        .char_clock (char_clock),
        .reset      (reset),
        .disp_active(disp_active),
        .disp_x     (disp_x),
        .disp_y     (disp_y),
        .pix_rgb    (pix_rgb),
        .pix_valid  (pix_valid),
        .cpu_valid  (cpu_valid),
        .cpu_ready  (cpu_ready),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .q_level    (q_level)
    );

    initial char_clock = 1'b0;
    always #5 char_clock = ~char_clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Framebuffer RAM: unwritten words read back as addr[11:0].
    logic [11:0] ram [logic [19:0]];
    always @(posedge char_clock) begin
        mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : mem_addr[11:0];
        if (mem_we)
            ram[mem_addr] = mem_wdata;
    end

    // Reference model: pending requests as a queue, memory as a map, and the
    // one-cycle RAM delay as a single "issued last cycle" record.
    typedef struct {
        logic        we;
        logic [19:0] addr;
        logic [11:0] wdata;
    } req_t;
    localparam int K_NONE = 0, K_DISP = 1, K_RD = 2;

    req_t        mq[$];
    logic [11:0] mmem [logic [19:0]];
    int          issued_kind;
    logic [11:0] issued_data;
    logic        m_pix_v, m_rv;
    logic [11:0] m_pix, m_rdata;
    logic [19:0] m_last;

    function automatic logic [11:0] mread(input logic [19:0] a);
        return mmem.exists(a) ? mmem[a] : a[11:0];
    endfunction

    function automatic logic [19:0] daddr(input logic [11:0] x, input logic [11:0] y);
        return 20'((y % 12'd1024) * 1024 + (x % 12'd1024));
    endfunction

    always @(posedge char_clock or posedge reset) begin
        if (reset) begin
            mq.delete();
            issued_kind = K_NONE;
            issued_data = '0;
            m_pix_v = 0; m_pix = '0; m_rv = 0; m_rdata = '0; m_last = '0;
        end else begin
            bit   was_full;
            req_t r;
            was_full = (mq.size() == 4);
            m_pix_v = (issued_kind == K_DISP);
            m_pix   = (issued_kind == K_DISP) ? issued_data : 12'h0;
            m_rv    = (issued_kind == K_RD);
            if (issued_kind == K_RD)
                m_rdata = issued_data;
            if (disp_active) begin
                m_last      = daddr(disp_x, disp_y);
                issued_kind = K_DISP;
                issued_data = mread(m_last);
            end else if (mq.size() > 0) begin
                r = mq.pop_front();
                m_last = r.addr;
                if (r.we) begin
                    mmem[r.addr] = r.wdata;
                    issued_kind  = K_NONE;
                end else begin
                    issued_kind = K_RD;
                    issued_data = mread(r.addr);
                end
            end else begin
                issued_kind = K_NONE;
            end
            if (cpu_valid && !was_full) begin
                r.we = cpu_we; r.addr = cpu_addr; r.wdata = cpu_wdata;
                mq.push_back(r);
            end
        end
    end

    always @(negedge char_clock) begin
        if (checking) begin
            chk("q_level", 32'(q_level), 32'(mq.size()));
            chk("cpu_ready", 32'(cpu_ready), 32'(mq.size() != 4));
            if (reset) begin
                chk("rst_mem_we", 32'(mem_we), 0);
                chk("rst_mem_addr", 32'(mem_addr), 0);
            end else if (disp_active) begin
                chk("disp_mem_we", 32'(mem_we), 0);
                chk("disp_mem_addr", 32'(mem_addr), 32'(daddr(disp_x, disp_y)));
            end else if (mq.size() > 0) begin
                chk("cpu_mem_we", 32'(mem_we), 32'(mq[0].we));
                chk("cpu_mem_addr", 32'(mem_addr), 32'(mq[0].addr));
                if (mq[0].we)
                    chk("cpu_mem_wdata", 32'(mem_wdata), 32'(mq[0].wdata));
            end else begin
                chk("idle_mem_we", 32'(mem_we), 0);
                chk("idle_mem_addr", 32'(mem_addr), 32'(m_last));
            end
            chk("pix_valid", 32'(pix_valid), 32'(m_pix_v));
            chk("pix_rgb", 32'(pix_rgb), 32'(m_pix));
            chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_rv));
            chk("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
        end
    end

    logic [11:0] rq[$];
    always @(negedge char_clock)
        if (checking && !reset && cpu_rvalid)
            rq.push_back(cpu_rdata);

    task automatic tick();
        @(posedge char_clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push_req(input logic we, input logic [19:0] a, input logic [11:0] d);
        cpu_valid = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        tick();
        cpu_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        reset = 1'b1; disp_active = 0; disp_x = '0; disp_y = '0;
        cpu_valid = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        @(posedge char_clock);
        #1;
        checking = 1;
        tick();
        settle();
        chk("rst_q_level", 32'(q_level), 0);
        chk("rst_cpu_ready", 32'(cpu_ready), 1);
        chk("rst_pix_valid", 32'(pix_valid), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        tick();
        reset = 1'b0;
        tick();

        // Visible line y=3: first pixel is word 0xC00.
        disp_y = 12'd3; disp_active = 1; disp_x = 0;
        tick();
        settle();
        chk("line_pix_valid_early", 32'(pix_valid), 0);
        disp_x = 1;
        tick();
        settle();
        chk("line_pix_valid", 32'(pix_valid), 1);
        chk("line_first_pix", 32'(pix_rgb), 32'h0C00);
        for (int x = 2; x < 1024; x++) begin
            disp_x = 12'(x);
            tick();
        end
        disp_active = 0;
        repeat (3) tick();

        // CPU write in blanking.
        push_req(1'b1, 20'h00005, 12'hABC);
        settle();
        chk("wr_mem_we", 32'(mem_we), 1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h5);
        chk("wr_mem_wdata", 32'(mem_wdata), 32'hABC);
        tick();
        chk("wr_q_level", 32'(q_level), 0);
        repeat (2) tick();

        // Read held off by 20 cycles of active video.
        rq.delete();
        disp_y = 0;
        for (int i = 0; i < 20; i++) begin
            disp_active = 1; disp_x = 12'(i);
            if (i == 0) begin
                cpu_valid = 1; cpu_we = 0; cpu_addr = 20'h00005;
            end
            settle();
            chk("hold_mem_we", 32'(mem_we), 0);
            chk("hold_mem_addr", 32'(mem_addr), i);
            tick();
            cpu_valid = 0;
        end
        disp_active = 0;
        tick();
        chk("hold_rvalid_early", 32'(cpu_rvalid), 0);
        tick();
        chk("hold_rvalid", 32'(cpu_rvalid), 1);
        chk("hold_rdata", 32'(cpu_rdata), 32'hABC);
        repeat (3) tick();

        // Queue full under active video; fifth request waits for blanking.
        rq.delete();
        disp_active = 1; disp_y = 5; disp_x = 0;
        push_req(1'b1, 20'h00100, 12'h111);
        push_req(1'b1, 20'h00101, 12'h222);
        push_req(1'b0, 20'h00100, 12'h000);
        push_req(1'b1, 20'h00100, 12'h333);
        chk("full_q_level", 32'(q_level), 4);
        chk("full_cpu_ready", 32'(cpu_ready), 0);
        cpu_valid = 1; cpu_we = 0; cpu_addr = 20'h00100; cpu_wdata = '0;
        repeat (2) tick();
        chk("full_still_4", 32'(q_level), 4);
        disp_active = 0;
        budget = 0;
        while (!cpu_ready && budget < 20) begin
            tick();
            budget++;
        end
        if (budget >= 20)
            chk("full_ready_timeout", 32'(budget), 0);
        tick();
        cpu_valid = 0;
        repeat (12) tick();
        chk("full_reads", 32'(rq.size()), 2);
        chk("full_read0", 32'(rq.size() > 0 ? rq[0] : 12'hFFF), 32'h111);
        chk("full_read1", 32'(rq.size() > 1 ? rq[1] : 12'hFFF), 32'h333);
        chk("full_drained", 32'(q_level), 0);

        // Simultaneous push and pop in blanking at level 2.
        rq.delete();
        disp_active = 1;
        push_req(1'b1, 20'h00200, 12'h0A1);
        push_req(1'b0, 20'h00200, 12'h000);
        chk("pp_level_before", 32'(q_level), 2);
        disp_active = 0;
        push_req(1'b1, 20'h00200, 12'h0A2);
        chk("pp_level_a", 32'(q_level), 2);
        push_req(1'b0, 20'h00200, 12'h000);
        chk("pp_level_b", 32'(q_level), 2);
        repeat (8) tick();
        chk("pp_reads", 32'(rq.size()), 2);
        chk("pp_read0", 32'(rq.size() > 0 ? rq[0] : 12'hFFF), 32'h0A1);
        chk("pp_read1", 32'(rq.size() > 1 ? rq[1] : 12'hFFF), 32'h0A2);

        // Reset with three queued requests and a CPU read in flight.
        disp_active = 1;
        push_req(1'b0, 20'h00005, 12'h000);
        push_req(1'b0, 20'h00100, 12'h000);
        push_req(1'b0, 20'h00200, 12'h000);
        push_req(1'b1, 20'h00300, 12'h777);
        disp_active = 0;
        tick();
        chk("mid_q_level", 32'(q_level), 3);
        reset = 1'b1;
        rq.delete();
        settle();
        chk("mid_rst_q_level", 32'(q_level), 0);
        chk("mid_rst_ready", 32'(cpu_ready), 1);
        chk("mid_rst_mem_we", 32'(mem_we), 0);
        chk("mid_rst_mem_addr", 32'(mem_addr), 0);
        chk("mid_rst_rvalid", 32'(cpu_rvalid), 0);
        chk("mid_rst_rdata", 32'(cpu_rdata), 0);
        chk("mid_rst_pix_valid", 32'(pix_valid), 0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("mid_no_rvalid", 32'(rq.size()), 0);
        chk("mid_ready_after", 32'(cpu_ready), 1);

        checking = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
